// File: rtl/window_buffer_kxk_stream.sv
// Streaming KxK sliding-window generator: raster-order pixels in, flattened KxK windows out.
// Optional WINBUF_SYNC_EN: an accepted in_sof beat restarts the frame position at (0,0).
module window_buffer_kxk_stream #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned IMG_WIDTH  = 8,
  parameter int unsigned IMG_HEIGHT = 8,
  parameter int unsigned K          = 3,
  parameter int unsigned STRIDE     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_sof,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [K*K*DATA_W-1:0] win_out,
  output logic                  out_last,
  output logic                  sof_err
);

  localparam int unsigned CW      = $clog2(IMG_WIDTH);
  localparam int unsigned RW      = $clog2(IMG_HEIGHT);
  localparam int unsigned PW      = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int unsigned LastRow = K - 1 + STRIDE * ((IMG_HEIGHT - K) / STRIDE);
  localparam int unsigned LastCol = K - 1 + STRIDE * ((IMG_WIDTH - K) / STRIDE);

  localparam logic [CW-1:0] ColMax  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] RowMax  = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] ColK    = CW'(K - 1);
  localparam logic [RW-1:0] RowK    = RW'(K - 1);
  localparam logic [CW-1:0] ColLast = CW'(LastCol);
  localparam logic [RW-1:0] RowLast = RW'(LastRow);
  localparam logic [PW-1:0] PhMax   = PW'(STRIDE - 1);

  logic [CW-1:0] col_q, col_d, eff_col;
  logic [RW-1:0] row_q, row_d, eff_row;
  logic [PW-1:0] cph_q, cph_d, eff_cph;
  logic [PW-1:0] rph_q, rph_d, eff_rph;
  logic          sof_hit, accept, emit, last_hit;

  logic [DATA_W-1:0] lb_q  [K-1][IMG_WIDTH];
  logic [DATA_W-1:0] win_q [K][K];
  logic [DATA_W-1:0] win_d [K][K];
  logic [K*K*DATA_W-1:0] win_flat;

  logic                  out_valid_q, out_last_q, sof_err_q;
  logic [K*K*DATA_W-1:0] win_out_q;

  function automatic logic [PW-1:0] ph_step(input logic [PW-1:0] ph);
    return (ph == PhMax) ? '0 : ph + 1'b1;
  endfunction

`ifdef WINBUF_SYNC_EN
  assign sof_hit = in_sof;
`else
  logic unused_sof;
  assign unused_sof = in_sof;
  assign sof_hit    = 1'b0;
`endif

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // A sof beat is processed as if it sat at (0,0) with both phases cleared.
  assign eff_col = sof_hit ? '0 : col_q;
  assign eff_row = sof_hit ? '0 : row_q;
  assign eff_cph = sof_hit ? '0 : cph_q;
  assign eff_rph = sof_hit ? '0 : rph_q;

  assign emit     = (eff_col >= ColK) && (eff_row >= RowK) && (eff_cph == '0) && (eff_rph == '0);
  assign last_hit = (eff_col == ColLast) && (eff_row == RowLast);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    cph_d = cph_q;
    rph_d = rph_q;
    if (accept) begin
      row_d = eff_row;
      rph_d = eff_rph;
      if (eff_col == ColMax) begin
        col_d = '0;
        cph_d = '0;
        if (eff_row == RowMax) begin
          row_d = '0;
          rph_d = '0;
        end else begin
          row_d = eff_row + 1'b1;
          rph_d = (eff_row + 1'b1 == RowK) ? '0 : ph_step(eff_rph);
        end
      end else begin
        col_d = eff_col + 1'b1;
        cph_d = (eff_col + 1'b1 == ColK) ? '0 : ph_step(eff_cph);
      end
    end
  end

  // Shift the window left one column; the new right column is line buffers plus the new pixel.
  always_comb begin
    win_d = win_q;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        win_d[i][j] = win_q[i][j+1];
      end
    end
    win_d[K-1][K-1] = in_data;
    for (int k = 0; k < K - 1; k++) begin
      win_d[K-2-k][K-1] = lb_q[k][eff_col];
    end
  end

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        win_flat[(i*K+j)*DATA_W +: DATA_W] = win_d[i][j];
      end
    end
  end

  // Storage is never reset: the emission gating guarantees stale entries are overwritten first.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_q[0][eff_col] <= in_data;
      for (int k = 1; k < K - 1; k++) begin
        lb_q[k][eff_col] <= lb_q[k-1][eff_col];
      end
      win_q <= win_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      cph_q       <= '0;
      rph_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      win_out_q   <= '0;
      sof_err_q   <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      cph_q     <= cph_d;
      rph_q     <= rph_d;
      sof_err_q <= accept && sof_hit && ((col_q != '0) || (row_q != '0));
      if (accept && emit) begin
        out_valid_q <= 1'b1;
        win_out_q   <= win_flat;
        out_last_q  <= last_hit;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign win_out   = win_out_q;
  assign out_last  = out_last_q;
  assign sof_err   = sof_err_q;

endmodule
